design_07: RTL and testbench



---
 rtl/design_07.sv | 69 ++++++
 tb/tb_design_07.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/design_07.sv
// Registered W-bit adder: captures a+b (mod 2^W) on start.
// Latency: y/valid one cycle after the start edge; valid is a per-start strobe.
// Backpressure: none; each result is presented for exactly one cycle.
module design_07 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         valid
);

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         load;
  logic [W-1:0] sum;

  // Carry-out is intentionally dropped: result is modulo 2^W.
  assign sum = a + b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // y holds its last sum until the next start, including across idle periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (load) begin
      y <= sum;
    end
  end

  assign valid = (state == DONE);

endmodule

// File: tb/tb_design_07.sv
// Directed bench for design_07: reset, single op, wrap, back-to-back, mid-op reset, random.
module tb_design_07;

  localparam int W = 12;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         valid;

  int checks = 0;
  int errors = 0;

  design_07 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .y     (y),
    .valid (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rsum;

    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_async_valid", {31'd0, valid}, 32'd0);
    check("reset_async_y", {20'd0, y}, 32'd0);

    // Reset held for 3 cycles while start toggles.
    a = 12'd7;
    b = 12'd9;
    for (int i = 0; i < 3; i++) begin
      start = ~start;
      tick();
      check("reset_hold_valid", {31'd0, valid}, 32'd0);
      check("reset_hold_y", {20'd0, y}, 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_reset_valid", {31'd0, valid}, 32'd0);
    tick();
    check("post_reset_valid2", {31'd0, valid}, 32'd0);

    // Single op.
    a = 12'd100; b = 12'd200; start = 1'b1;
    tick();
    start = 1'b0;
    check("single_valid", {31'd0, valid}, 32'd1);
    check("single_y", {20'd0, y}, 32'd300);
    a = 12'd55; b = 12'd66;
    tick();
    check("single_after_valid", {31'd0, valid}, 32'd0);
    check("single_hold_y", {20'd0, y}, 32'd300);
    tick();
    check("operand_change_y", {20'd0, y}, 32'd300);

    // Wrap-around.
    a = 12'd4095; b = 12'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("wrap0_valid", {31'd0, valid}, 32'd1);
    check("wrap0_y", {20'd0, y}, 32'd0);
    tick();
    a = 12'd4000; b = 12'd200; start = 1'b1;
    tick();
    start = 1'b0;
    check("wrap1_valid", {31'd0, valid}, 32'd1);
    check("wrap1_y", {20'd0, y}, 32'd104);
    tick();
    check("wrap1_after_valid", {31'd0, valid}, 32'd0);

    // Back-to-back.
    a = 12'd1; b = 12'd2; start = 1'b1;
    tick();
    check("b2b0_valid", {31'd0, valid}, 32'd1);
    check("b2b0_y", {20'd0, y}, 32'd3);
    a = 12'd10; b = 12'd20;
    tick();
    check("b2b1_valid", {31'd0, valid}, 32'd1);
    check("b2b1_y", {20'd0, y}, 32'd30);
    a = 12'd1000; b = 12'd23;
    tick();
    start = 1'b0;
    check("b2b2_valid", {31'd0, valid}, 32'd1);
    check("b2b2_y", {20'd0, y}, 32'd1023);
    tick();
    check("b2b_end_valid", {31'd0, valid}, 32'd0);
    check("b2b_end_y", {20'd0, y}, 32'd1023);

    // Reset mid-op: result present, then reset before next edge.
    a = 12'd5; b = 12'd6; start = 1'b1;
    tick();
    check("midop_pre_valid", {31'd0, valid}, 32'd1);
    check("midop_pre_y", {20'd0, y}, 32'd11);
    #2;
    rst_n = 1'b0;
    #1;
    check("midop_async_valid", {31'd0, valid}, 32'd0);
    check("midop_async_y", {20'd0, y}, 32'd0);
    tick();
    check("midop_hold_valid", {31'd0, valid}, 32'd0);
    check("midop_hold_y", {20'd0, y}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("midop_release_valid", {31'd0, valid}, 32'd0);
    tick();
    check("midop_release_valid2", {31'd0, valid}, 32'd0);
    check("midop_release_y", {20'd0, y}, 32'd0);

    // Random 10-bit operands, isolated starts.
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom_range(0, 1023));
      rb = W'($urandom_range(0, 1023));
      rsum = ra + rb;
      a = ra; b = rb; start = 1'b1;
      tick();
      start = 1'b0;
      a = W'($urandom_range(0, 4095));
      b = W'($urandom_range(0, 4095));
      check("rand_valid", {31'd0, valid}, 32'd1);
      check("rand_y", {20'd0, y}, {20'd0, rsum});
      tick();
      check("rand_idle_valid", {31'd0, valid}, 32'd0);
      check("rand_idle_y", {20'd0, y}, {20'd0, rsum});
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
